hcf_engine_param: RTL and testbench

- Next-generation HCF (GCD) unit. Replaces the fixed 16-bit datapath/controller pair with one parametrised block.
- Operand width and algorithm are selectable: subtractive or binary (Stein).
- Both operands load in parallel on a start handshake.
- Adds explicit busy/done status, zero-operand handling, and a saturating iteration counter for performance monitoring.

---
 rtl/hcf_engine_param.sv | 142 ++++++++++++++
 tb/tb_hcf_engine_param.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hcf_engine_param.sv
// hcf_engine_param: iterative greatest-common-factor engine.
// Both operands load together on an accepted start. The engine then runs
// either repeated subtraction (ALGO = 0) or binary Stein steps (ALGO = 1)
// until one operand is zero or both are equal. The result is held in DONE.
//
// Handshake: start is only looked at in IDLE or DONE. An accepted start
// raises busy on the same edge. done rises on the edge that registers the
// result and stays high until the next accepted start or rst. hcf_out,
// zero_err and iter_count are meaningful while done = 1.
module hcf_engine_param #(
   parameter int WIDTH = 16,
   parameter int ALGO  = 0,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hcf_out,
   output logic             zero_err,
   output logic [CNT_W-1:0] iter_count,
   output logic [1:0]       dbg_state
);

   localparam int K_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_STEP = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [K_W-1:0]   r_k;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_hcf;
   logic             r_zero_err;
   logic [CNT_W-1:0] r_iter;

   logic             w_a_zero;
   logic             w_b_zero;
   logic             w_a_gt_b;
   logic             w_iter_sat;

   assign w_a_zero   = (r_a == '0);
   assign w_b_zero   = (r_b == '0);
   assign w_a_gt_b   = (r_a > r_b);
   assign w_iter_sat = (r_iter == {CNT_W{1'b1}});

   assign busy       = r_busy;
   assign done       = r_done;
   assign hcf_out    = r_hcf;
   assign zero_err   = r_zero_err;
   assign iter_count = r_iter;
   assign dbg_state  = r_state;

   // Controller and datapath: load on start, iterate in STEP, hold in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_a        <= '0;
         r_b        <= '0;
         r_k        <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_hcf      <= '0;
         r_zero_err <= 1'b0;
         r_iter     <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_a        <= a_in;
                  r_b        <= b_in;
                  r_k        <= '0;
                  r_iter     <= '0;
                  r_done     <= 1'b0;
                  r_zero_err <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= S_STEP;
               end
            end
            S_STEP: begin
               if (w_a_zero || w_b_zero) begin
                  // One zero operand: the other one (scaled by 2^k) is the answer.
                  r_hcf      <= (r_a | r_b) << r_k;
                  r_zero_err <= w_a_zero && w_b_zero;
                  r_done     <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= S_DONE;
               end else if (r_a == r_b) begin
                  // Converged; this cycle does not modify A/B so it is not counted.
                  r_hcf   <= r_a << r_k;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_DONE;
               end else begin
                  if (!w_iter_sat) begin
                     r_iter <= r_iter + CNT_W'(1);
                  end
                  if (ALGO == 0) begin
                     // Larger operand is always the minuend, so no underflow.
                     if (w_a_gt_b) begin
                        r_a <= r_a - r_b;
                     end else begin
                        r_b <= r_b - r_a;
                     end
                  end else begin
                     // Stein: strip common factors of two into k, then
                     // halve lone even operands, else halve the odd difference.
                     if (!r_a[0] && !r_b[0]) begin
                        r_a <= r_a >> 1;
                        r_b <= r_b >> 1;
                        r_k <= r_k + K_W'(1);
                     end else if (!r_a[0]) begin
                        r_a <= r_a >> 1;
                     end else if (!r_b[0]) begin
                        r_b <= r_b >> 1;
                     end else if (w_a_gt_b) begin
                        r_a <= (r_a - r_b) >> 1;
                     end else begin
                        r_b <= (r_b - r_a) >> 1;
                     end
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hcf_engine_param.sv
// Bench for hcf_engine_param. Four instances cover the parameter sets:
//   u0: WIDTH 16, subtractive    u1: WIDTH 16, Stein
//   u2: WIDTH 8,  Stein          u3: WIDTH 8,  subtractive, CNT_W 3
// The reference model derives the result from Euclid with division and the
// subtractive step count from the sum of quotients; Stein step counts come
// from applying the halving rules to plain integers.
module tb_hcf_engine_param;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        st [4];
   logic [15:0] ai [4];
   logic [15:0] bi [4];

   logic        busy_w [4];
   logic        done_w [4];
   logic        zerr_w [4];
   logic [15:0] hcf_w  [4];
   logic [15:0] cnt_w  [4];
   logic [1:0]  dbg_w  [4];

   logic        busy0, busy1, busy2, busy3;
   logic        done0, done1, done2, done3;
   logic        zerr0, zerr1, zerr2, zerr3;
   logic [15:0] hcf0, hcf1, cnt0, cnt1, cnt2;
   logic [7:0]  hcf2, hcf3;
   logic [2:0]  cnt3;
   logic [1:0]  dbg0, dbg1, dbg2, dbg3;

   hcf_engine_param #(.WIDTH(16), .ALGO(0), .CNT_W(16)) u0 (
      .clk(clk), .rst(rst), .start(st[0]), .a_in(ai[0]), .b_in(bi[0]),
      .busy(busy0), .done(done0), .hcf_out(hcf0), .zero_err(zerr0),
      .iter_count(cnt0), .dbg_state(dbg0));
   hcf_engine_param #(.WIDTH(16), .ALGO(1), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .start(st[1]), .a_in(ai[1]), .b_in(bi[1]),
      .busy(busy1), .done(done1), .hcf_out(hcf1), .zero_err(zerr1),
      .iter_count(cnt1), .dbg_state(dbg1));
   hcf_engine_param #(.WIDTH(8), .ALGO(1), .CNT_W(16)) u2 (
      .clk(clk), .rst(rst), .start(st[2]), .a_in(ai[2][7:0]), .b_in(bi[2][7:0]),
      .busy(busy2), .done(done2), .hcf_out(hcf2), .zero_err(zerr2),
      .iter_count(cnt2), .dbg_state(dbg2));
   hcf_engine_param #(.WIDTH(8), .ALGO(0), .CNT_W(3)) u3 (
      .clk(clk), .rst(rst), .start(st[3]), .a_in(ai[3][7:0]), .b_in(bi[3][7:0]),
      .busy(busy3), .done(done3), .hcf_out(hcf3), .zero_err(zerr3),
      .iter_count(cnt3), .dbg_state(dbg3));

   assign busy_w[0] = busy0; assign busy_w[1] = busy1;
   assign busy_w[2] = busy2; assign busy_w[3] = busy3;
   assign done_w[0] = done0; assign done_w[1] = done1;
   assign done_w[2] = done2; assign done_w[3] = done3;
   assign zerr_w[0] = zerr0; assign zerr_w[1] = zerr1;
   assign zerr_w[2] = zerr2; assign zerr_w[3] = zerr3;
   assign hcf_w[0]  = hcf0;  assign hcf_w[1]  = hcf1;
   assign hcf_w[2]  = {8'h00, hcf2};
   assign hcf_w[3]  = {8'h00, hcf3};
   assign cnt_w[0]  = cnt0;  assign cnt_w[1]  = cnt1;
   assign cnt_w[2]  = cnt2;
   assign cnt_w[3]  = {13'd0, cnt3};
   assign dbg_w[0]  = dbg0;  assign dbg_w[1]  = dbg1;
   assign dbg_w[2]  = dbg2;  assign dbg_w[3]  = dbg3;

   // ---------------- scoreboard ----------------
   typedef struct {
      int id;
      int a;
      int b;
      int hcf;
      int cnt;
      int zerr;
      int steps;
      int start_n;
   } exp_t;

   exp_t exp_q[$];
   int   tests_run    = 0;
   int   tests_failed = 0;

   task automatic chk(input string name, input int act, input int exp_v);
      tests_run++;
      if (act != exp_v) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endtask

   // Reference model from the algorithm definitions.
   function automatic void ref_model(input int id, input int a, input int b,
                                     output int hcf, output int cnt,
                                     output int zerr, output int steps);
      int x, y, t, sum, cmax;
      bit algo;
      algo = (id == 1) || (id == 2);
      cmax = (id == 3) ? 7 : 65535;
      zerr = 0;
      steps = 0;
      if (a == 0 && b == 0) begin
         hcf  = 0;
         zerr = 1;
      end else if (a == 0 || b == 0) begin
         hcf = a + b;
      end else begin
         x = a; y = b; sum = 0;
         while (y != 0) begin
            sum += x / y;
            t = x % y;
            x = y;
            y = t;
         end
         hcf = x;
         if (!algo) begin
            steps = sum - 1;
         end else begin
            x = a; y = b;
            while (x != y) begin
               if (x % 2 == 0 && y % 2 == 0) begin x = x / 2; y = y / 2; end
               else if (x % 2 == 0) x = x / 2;
               else if (y % 2 == 0) y = y / 2;
               else if (x > y) x = (x - y) / 2;
               else y = (y - x) / 2;
               steps++;
            end
         end
      end
      cnt = (steps > cmax) ? cmax : steps;
   endfunction

   // ---------------- monitor ----------------
   logic prev_done [4];
   int   held_hcf  [4];

   initial begin
      for (int i = 0; i < 4; i++) begin
         prev_done[i] = 1'b0;
         held_hcf[i]  = 0;
      end
   end

   always @(negedge clk) begin : mon
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         if (!rst && done_w[i] && !prev_done[i]) begin
            if (exp_q.size() == 0) begin
               chk($sformatf("unexpected_done u%0d", i), 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk($sformatf("instance u%0d (%0d,%0d)", i, e.a, e.b), i, e.id);
               chk($sformatf("hcf u%0d (%0d,%0d)", i, e.a, e.b), hcf_w[i], e.hcf);
               chk($sformatf("iter u%0d (%0d,%0d)", i, e.a, e.b), cnt_w[i], e.cnt);
               chk($sformatf("zero_err u%0d (%0d,%0d)", i, e.a, e.b), zerr_w[i], e.zerr);
               chk($sformatf("busy_at_done u%0d", i), busy_w[i], 0);
               chk($sformatf("latency u%0d (%0d,%0d)", i, e.a, e.b),
                   cyc - e.start_n, e.steps + 1);
               held_hcf[i] = e.hcf;
            end
         end else if (!rst && done_w[i] && prev_done[i]) begin
            chk($sformatf("hold_hcf u%0d", i), hcf_w[i], held_hcf[i]);
         end
         prev_done[i] = done_w[i];
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_op(input int id, input int a, input int b);
      exp_t e;
      int h, c, z, s;
      ref_model(id, a, b, h, c, z, s);
      @(negedge clk);
      st[id] = 1'b1;
      ai[id] = a[15:0];
      bi[id] = b[15:0];
      @(posedge clk);
      #1;
      st[id] = 1'b0;
      e.id = id; e.a = a; e.b = b; e.hcf = h; e.cnt = c; e.zerr = z;
      e.steps = s; e.start_n = cyc;
      exp_q.push_back(e);
      chk($sformatf("busy_after_start u%0d", id), busy_w[id], 1);
      chk($sformatf("done_drop u%0d", id), done_w[id], 0);
   endtask

   task automatic wait_result(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         chk("result_timeout", exp_q.size(), 0);
         exp_q.delete();
      end
   endtask

   task automatic run(input int id, input int a, input int b);
      start_op(id, a, b);
      wait_result(3000);
   endtask

   task automatic chk_all_zero(input string tag, input int i);
      chk($sformatf("%s busy u%0d", tag, i), busy_w[i], 0);
      chk($sformatf("%s done u%0d", tag, i), done_w[i], 0);
      chk($sformatf("%s hcf u%0d", tag, i), hcf_w[i], 0);
      chk($sformatf("%s zero_err u%0d", tag, i), zerr_w[i], 0);
      chk($sformatf("%s iter u%0d", tag, i), cnt_w[i], 0);
      chk($sformatf("%s state u%0d", tag, i), dbg_w[i], 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int a, b;
      for (int i = 0; i < 4; i++) begin
         st[i] = 1'b0;
         ai[i] = '0;
         bi[i] = '0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) chk_all_zero("reset", i);
      @(negedge clk);
      rst = 1'b0;

      // Directed cases from the algorithm examples.
      run(0, 143, 78);
      chk("tp_143_78 hcf", hcf_w[0], 13);
      chk("tp_143_78 iter", cnt_w[0], 6);
      run(1, 48, 18);
      chk("tp_stein_48_18 hcf", hcf_w[1], 6);
      chk("tp_stein_48_18 iter", cnt_w[1], 5);
      run(0, 48, 18);
      chk("tp_sub_48_18 iter", cnt_w[0], 4);
      run(0, 0, 25);
      chk("tp_0_25 hcf", hcf_w[0], 25);
      run(0, 0, 0);
      chk("tp_0_0 zero_err", zerr_w[0], 1);
      run(1, 0, 0);
      run(2, 255, 255);
      chk("tp_255_255 iter", cnt_w[2], 0);
      run(2, 128, 64);
      chk("tp_128_64 hcf", hcf_w[2], 64);
      run(2, 0, 7);
      run(3, 200, 1);
      chk("tp_sat iter", cnt_w[3], 7);
      chk("tp_sat hcf", hcf_w[3], 1);

      // Start during a busy run is ignored; restart from DONE is taken.
      start_op(0, 143, 78);
      repeat (2) @(posedge clk);
      @(negedge clk);
      st[0] = 1'b1; ai[0] = 16'd10; bi[0] = 16'd4;
      @(negedge clk);
      st[0] = 1'b0;
      wait_result(3000);
      chk("ignored_start hcf", hcf_w[0], 13);
      run(0, 10, 4);
      chk("restart hcf", hcf_w[0], 2);

      // Reset three cycles into a run aborts it.
      start_op(0, 143, 78);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_all_zero("mid_reset", 0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      run(0, 143, 78);
      chk("after_reset hcf", hcf_w[0], 13);

      // Randomized operands on every configuration.
      for (int n = 0; n < 8; n++) begin
         a = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 2000);
         b = $urandom_range(1, 2000);
         run(0, a, b);
         a = $urandom_range(0, 65535);
         b = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 65535);
         run(1, a, b);
         run(2, $urandom_range(0, 255), $urandom_range(1, 255));
         run(3, $urandom_range(1, 255), $urandom_range(0, 255));
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
